conv_core_param: RTL and testbench

- Parametrised streaming 2-D convolution core. It takes a raster-ordered single-channel image and produces NUM_CH output feature channels in parallel, using KxK kernels held in an internal, runtime-loadable weight/bias register file.
- It supersedes the fixed 5x5/6-channel first-layer core, which had hard-wired weight ports. It adds frame sync, optional ReLU, a config write port with busy lockout, and a frame-done indication.
- It sits between the pixel source (line-stream input) and the pooling stage.

---
 rtl/conv_core_param.sv | 126 ++++++++++++
 tb/tb_conv_core_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_core_param.sv
// conv_core_param: streaming KxK 2-D convolution producing NUM_CH channels from a runtime-loadable weight file
module conv_core_param #(
  parameter int IMG_WIDTH = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int K = 5,
  parameter int NUM_CH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BIAS_WIDTH = 32,
  parameter int OUT_WIDTH = 32,
  parameter int CFG_DEPTH = NUM_CH * (K * K + 1),
  parameter int CFG_AW = $clog2(CFG_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  input  logic                        sof_in,
  input  logic [DATA_WIDTH-1:0]       pixel_in,
  input  logic                        relu_en,
  input  logic                        cfg_we,
  input  logic [CFG_AW-1:0]           cfg_addr,
  input  logic [BIAS_WIDTH-1:0]       cfg_wdata,
  output logic                        cfg_err,
  output logic                        busy,
  output logic [NUM_CH*OUT_WIDTH-1:0] result,
  output logic                        result_valid,
  output logic                        frame_done
);
  localparam int KK = K * K;
  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  logic [CW-1:0] col, ecol;
  logic [RW-1:0] row, erow;
  logic signed [DATA_WIDTH-1:0] lb [K-1][IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] win [K][K];
  logic signed [DATA_WIDTH-1:0] vcol [K];
  logic signed [WEIGHT_WIDTH-1:0] wt [NUM_CH][KK];
  logic signed [BIAS_WIDTH-1:0] bias [NUM_CH];
  logic signed [PW-1:0] prod [NUM_CH][KK];
  logic signed [OUT_WIDTH-1:0] sum_c [NUM_CH];
  logic signed [OUT_WIDTH-1:0] sum_r [NUM_CH];
  logic [2:0] v_p, l_p, r_p;
  logic relu_q, first, relu_cur, win_ok, last, cfg_ok;
  // a sof pixel forces position (0,0); the relu setting follows every pixel through the pipe
  always_comb begin
    ecol = sof_in ? '0 : col;
    erow = sof_in ? '0 : row;
    first = valid_in && (sof_in || (row == '0 && col == '0));
    relu_cur = first ? relu_en : relu_q;
    win_ok = valid_in && erow >= RW'(K - 1) && ecol >= CW'(K - 1);
    last = erow == RW'(IMG_HEIGHT - 1) && ecol == CW'(IMG_WIDTH - 1);
    cfg_ok = cfg_we && !busy && !valid_in && ({1'b0, cfg_addr} < (CFG_AW + 1)'(CFG_DEPTH));
    vcol[K-1] = pixel_in;
    for (int i = 0; i < K - 1; i++) vcol[K-2-i] = lb[i][ecol];
  end
  always_comb
    for (int c = 0; c < NUM_CH; c++) begin
      sum_c[c] = OUT_WIDTH'(bias[c]);
      for (int i = 0; i < KK; i++) sum_c[c] = sum_c[c] + OUT_WIDTH'(prod[c][i]);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < KK; i++) wt[c][i] <= '0;
        bias[c] <= '0;
      end
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < KK; i++)
          if (cfg_ok && cfg_addr == CFG_AW'(c * (KK + 1) + i)) wt[c][i] <= cfg_wdata[WEIGHT_WIDTH-1:0];
        if (cfg_ok && cfg_addr == CFG_AW'(c * (KK + 1) + KK)) bias[c] <= cfg_wdata;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      relu_q <= 1'b0;
      busy <= 1'b0;
      for (int i = 0; i < K - 1; i++)
        for (int j = 0; j < IMG_WIDTH; j++) lb[i][j] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else begin
      if (valid_in) begin
        col <= ecol == CW'(IMG_WIDTH - 1) ? '0 : ecol + 1'b1;
        row <= ecol != CW'(IMG_WIDTH - 1) ? erow : erow == RW'(IMG_HEIGHT - 1) ? '0 : erow + 1'b1;
        relu_q <= relu_cur;
        lb[0][ecol] <= pixel_in;
        for (int i = 1; i < K - 1; i++) lb[i][ecol] <= lb[i-1][ecol];
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
          win[r][K-1] <= vcol[r];
        end
      end
      if (valid_in && (!busy || sof_in)) busy <= 1'b1;
      else if (frame_done) busy <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_p <= '0;
      l_p <= '0;
      r_p <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < KK; i++) prod[c][i] <= '0;
        sum_r[c] <= '0;
      end
      result <= '0;
      result_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      v_p <= {v_p[1:0], win_ok};
      l_p <= {l_p[1:0], last};
      r_p <= {r_p[1:0], relu_cur};
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < KK; i++) prod[c][i] <= PW'(win[i/K][i%K]) * PW'(wt[c][i]);
        sum_r[c] <= sum_c[c];
        if (v_p[2]) result[c*OUT_WIDTH +: OUT_WIDTH] <= (r_p[2] && sum_r[c][OUT_WIDTH-1]) ? '0 : sum_r[c];
      end
      result_valid <= v_p[2];
      frame_done <= v_p[2] && l_p[2];
    end
endmodule

// File: tb/tb_conv_core_param.sv
// tb_conv_core_param: directed scoreboard bench for the streaming convolution core
module tb_conv_core_param;
  localparam int W = 28, H = 28, K = 5, NC = 6, DW = 8, WW = 8, BW = 32, OW = 32;
  localparam int KK = K * K, DEPTH = NC * (KK + 1), AW = $clog2(DEPTH);
  logic clk = 0, rst_n = 0, valid_in = 0, sof_in = 0, relu_en = 0, cfg_we = 0;
  logic [DW-1:0] pixel_in = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic [BW-1:0] cfg_wdata = '0;
  logic cfg_err, busy, result_valid, frame_done;
  logic [NC*OW-1:0] result;
  typedef struct {logic [NC*OW-1:0] res; logic fd; int at;} sb_t;
  sb_t sb[$];
  sb_t m;
  logic [NC*OW-1:0] got[$], ref1[$];
  int checks = 0, errors = 0, cyc = 0, fd_cnt = 0;
  int wt[NC][KK], bias[NC], img[H][W];
  int br = 0, bc = 0;
  bit brelu = 0, px_we = 0;
  conv_core_param #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .K(K), .NUM_CH(NC), .DATA_WIDTH(DW),
    .WEIGHT_WIDTH(WW), .BIAS_WIDTH(BW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in), .pixel_in(pixel_in),
    .relu_en(relu_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .busy(busy), .result(result), .result_valid(result_valid),
    .frame_done(frame_done));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (result_valid) begin
      got.push_back(result);
      if (frame_done) fd_cnt++;
      checks++;
      assert (sb.size() != 0) else begin errors++; $error("FAIL unexpected_result got=%h expected none", result); end
      if (sb.size() != 0) begin
        m = sb.pop_front();
        checks++;
        assert (result === m.res) else begin errors++; $error("FAIL result got=%h exp=%h", result, m.res); end
        checks++;
        assert (frame_done === m.fd) else begin errors++; $error("FAIL frame_done got=%b exp=%b", frame_done, m.fd); end
        checks++;
        assert (cyc === m.at + 3) else begin errors++; $error("FAIL latency got_edge=%0d exp_edge=%0d", cyc, m.at + 3); end
      end
    end else begin
      checks++;
      assert (frame_done === 1'b0) else begin errors++; $error("FAIL lone_frame_done got=%b exp=0", frame_done); end
    end
  end
  task automatic chk(input string tag, input logic [63:0] g, input logic [63:0] e);
    checks++;
    assert (g === e) else begin errors++; $error("FAIL %s got=%0h exp=%0h", tag, g, e); end
  endtask
  task automatic px(input int p, input bit sof, input int gap);
    logic signed [DW-1:0] p8;
    sb_t e;
    int acc;
    repeat (gap) begin @(negedge clk); valid_in = 0; sof_in = 0; cfg_we = 0; end
    @(negedge clk);
    p8 = DW'(p);
    valid_in = 1; sof_in = sof; pixel_in = p8;
    cfg_we = px_we; cfg_addr = '0; cfg_wdata = 55;
    if (sof) begin br = 0; bc = 0; end
    if (br == 0 && bc == 0) brelu = relu_en;
    img[br][bc] = int'(p8);
    if (br >= K - 1 && bc >= K - 1) begin
      for (int ch = 0; ch < NC; ch++) begin
        acc = bias[ch];
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) acc += wt[ch][r*K+c] * img[br-K+1+r][bc-K+1+c];
        if (brelu && acc < 0) acc = 0;
        e.res[ch*OW +: OW] = acc;
      end
      e.fd = (br == H - 1 && bc == W - 1);
      e.at = cyc + 1;
      sb.push_back(e);
    end
    if (bc == W - 1) begin bc = 0; br = (br == H - 1) ? 0 : br + 1; end
    else bc++;
  endtask
  task automatic frame(input bit ramp, input int val, input int gap, input int from, input int to);
    for (int i = from; i < to; i++) px(ramp ? i : val, i == 0, gap != 0 ? int'($urandom_range(gap, 0)) : 0);
  endtask
  task automatic drain();
    @(negedge clk); valid_in = 0; sof_in = 0; cfg_we = 0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain", sb.size(), 0);
    @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask
  task automatic cfg_wr(input int a, input int d, input bit err);
    @(negedge clk); valid_in = 0; sof_in = 0; cfg_we = 1; cfg_addr = AW'(a); cfg_wdata = d;
    if (!err) begin
      if (a % (KK + 1) == KK) bias[a/(KK+1)] = d;
      else wt[a/(KK+1)][a%(KK+1)] = int'($signed(d[WW-1:0]));
    end
    @(negedge clk); cfg_we = 0;
    chk("cfg_err", cfg_err, err);
  endtask
  task automatic seq_vs_ref(input string tag);
    int nd = 0;
    for (int i = 0; i < got.size() && i < ref1.size(); i++) if (got[i] !== ref1[i]) nd++;
    chk(tag, nd, 0);
    chk("count", got.size(), 576);
    chk("fd_count", fd_cnt, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int nz;
    foreach (wt[c, i]) wt[c][i] = 0;
    foreach (bias[c]) bias[c] = 0;
    repeat (2) @(negedge clk);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_res", result[63:0], 0);
    rst_n = 1;
    cfg_wr(12, 1, 0);
    for (int i = 0; i < KK; i++) cfg_wr(KK + 1 + i, 1, 0);
    cfg_wr(2 * KK + 1, 10, 0);
    got.delete(); fd_cnt = 0;
    frame(1, 0, 0, 0, 2);
    chk("busy_rise", busy, 1);
    frame(1, 0, 0, 2, W * H);
    drain();
    chk("s1_count", got.size(), 576);
    chk("s1_ch0", got[0][31:0], 58);
    chk("s1_ch1", got[0][63:32], 1460);
    chk("s1_fd", fd_cnt, 1);
    ref1 = got;
    got.delete(); fd_cnt = 0;
    frame(1, 0, 3, 0, W * H);
    drain();
    seq_vs_ref("gap_seq");
    got.delete(); fd_cnt = 0;
    frame(1, 0, 0, 0, 100);
    frame(1, 0, 0, 0, 2);
    chk("sof_busy", busy, 1);
    frame(1, 0, 0, 2, W * H);
    drain();
    seq_vs_ref("abort_seq");
    got.delete(); fd_cnt = 0;
    frame(1, 0, 0, 0, 200);
    cfg_wr(12, 5, 1);
    frame(1, 0, 0, 200, W * H);
    drain();
    cfg_wr(DEPTH, 7, 1);
    @(negedge clk);
    chk("err_pulse", cfg_err, 0);
    got.delete(); fd_cnt = 0;
    px_we = 1;
    frame(1, 0, 0, 0, 1);
    px_we = 0;
    @(negedge clk); cfg_we = 0; valid_in = 0; sof_in = 0;
    chk("cfg_first_px", cfg_err, 1);
    frame(1, 0, 0, 1, W * H);
    drain();
    seq_vs_ref("cfg_err_seq");
    for (int i = 0; i < KK; i++) cfg_wr(i, -128, 0);
    cfg_wr(KK, -1, 0);
    for (int i = 0; i < KK; i++) cfg_wr(2 * (KK + 1) + i, 1, 0);
    cfg_wr(2 * (KK + 1) + KK, 0, 0);
    relu_en = 0;
    got.delete();
    frame(0, -128, 0, 0, W * H);
    drain();
    chk("neg_ch0", got[0][31:0], 409599);
    got.delete();
    frame(0, -1, 0, 0, W * H);
    drain();
    chk("ch2_norelu", got[0][95:64], 32'hFFFFFFE7);
    relu_en = 1;
    got.delete();
    frame(0, -1, 0, 0, W * H);
    drain();
    chk("ch2_relu", got[0][95:64], 0);
    relu_en = 0;
    frame(1, 0, 0, 0, 150);
    @(negedge clk); valid_in = 0; rst_n = 0;
    @(negedge clk);
    chk("mid_rst_rv", result_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fd", frame_done, 0);
    @(negedge clk); rst_n = 1;
    sb.delete(); got.delete(); fd_cnt = 0; br = 0; bc = 0;
    foreach (wt[c, i]) wt[c][i] = 0;
    foreach (bias[c]) bias[c] = 0;
    frame(1, 0, 0, 0, W * H);
    drain();
    nz = 0;
    foreach (got[i]) if (got[i] !== '0) nz++;
    chk("post_rst_zero", nz, 0);
    chk("post_rst_count", got.size(), 576);
    chk("post_rst_fd", fd_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
